// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer: feeds one 8-bit slice per cycle into an
// external combinational adder, chains its carry, and assembles the full result.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  output logic [7:0]           add_x,
  output logic [7:0]           add_y,
  output logic                 add_c0,
  input  logic [7:0]           add_s,
  input  logic                 add_c8,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_n;
  logic               load_s;
  logic               last_s;
  logic               ovf_s;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  assign last_s = (state_r == RUN) && (idx_r == LAST_IDX);
  // b_r already holds ~B in subtract mode, so one overflow rule covers both modes.
  assign ovf_s  = (a_r[W-1] == b_r[W-1]) && (add_s[7] != a_r[W-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode; a start is only honoured outside RUN.
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_n == RUN);
      done_r <= (state_n == DONE);
    end
  end

  // Operand latch, slice accumulation and carry chaining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      a_r     <= a;
      b_r     <= sub ? ~b : b;
      carry_r <= sub ? 1'b1 : cin;
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (state_r == RUN) begin
      sum_r[{idx_r, 3'b000} +: 8] <= add_s;
      carry_r                     <= add_c8;
      if (last_s) begin
        cout_r <= add_c8;
        ovf_r  <= ovf_s;
      end else begin
        idx_r  <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Adder drive is only live in RUN so the adder sees zeros otherwise.
  always_comb begin
    add_x  = 8'h00;
    add_y  = 8'h00;
    add_c0 = 1'b0;
    if (state_r == RUN) begin
      add_x  = a_r[{idx_r, 3'b000} +: 8];
      add_y  = b_r[{idx_r, 3'b000} +: 8];
      add_c0 = carry_r;
    end else begin
      add_x  = 8'h00;
      add_y  = 8'h00;
      add_c0 = 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq with a behavioural 8-bit adder attached and an
// arithmetic reference model for the full-width result and per-slice traffic.
module tb_multiword_add_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_c0;
  logic [7:0]  add_s;
  logic        add_c8;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  multiword_add_seq #(.WORDS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .add_x  (add_x),
    .add_y  (add_y),
    .add_c0 (add_c0),
    .add_s  (add_s),
    .add_c8 (add_c8),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  // Stand-in for the combinational 8-bit adder.
  assign {add_c8, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'b0, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_sum"}, {32'b0, sum}, 64'd0);
    chk({tag, "_cout"}, {63'b0, cout}, 64'd0);
    chk({tag, "_ovf"}, {63'b0, ovf}, 64'd0);
    chk({tag, "_add_x"}, {56'b0, add_x}, 64'd0);
    chk({tag, "_add_y"}, {56'b0, add_y}, 64'd0);
    chk({tag, "_add_c0"}, {63'b0, add_c0}, 64'd0);
  endtask

  // One operation: expected values come from plain arithmetic on the operands.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tsub, input logic tcin,
                        input bit glitch, input bit b2b);
    logic [31:0] bb;
    logic        c0;
    logic [31:0] exp_sum;
    logic [63:0] wide;
    logic        exp_cout;
    logic        exp_ovf;
    longint      exact;
    logic [63:0] mask;
    logic [63:0] part;

    bb      = tsub ? ~tb_v : tb_v;
    c0      = tsub ? 1'b1 : tcin;
    exp_sum = tsub ? (ta - tb_v) : (ta + tb_v + {31'b0, tcin});
    wide    = {32'b0, ta} + {32'b0, tb_v} + {63'b0, tcin};
    exp_cout = tsub ? (ta >= tb_v) : wide[32];
    exact   = tsub ? (longint'($signed(ta)) - longint'($signed(tb_v)))
                   : (longint'($signed(ta)) + longint'($signed(tb_v)) + longint'(tcin));
    exp_ovf = (exact != longint'($signed(exp_sum)));

    a = ta; b = tb_v; sub = tsub; cin = tcin; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mask = (64'd1 << (8 * k)) - 64'd1;
      part = ({32'b0, ta} & mask) + ({32'b0, bb} & mask) + {63'b0, c0};
      chk("run_busy", {63'b0, busy}, 64'd1);
      chk("run_done", {63'b0, done}, 64'd0);
      chk("add_x", {56'b0, add_x}, ({32'b0, ta} >> (8 * k)) & 64'hFF);
      chk("add_y", {56'b0, add_y}, ({32'b0, bb} >> (8 * k)) & 64'hFF);
      chk("add_c0", {63'b0, add_c0}, (part >> (8 * k)) & 64'd1);
      if (glitch && (k == 1 || k == 2)) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", {63'b0, done}, 64'd1);
    chk("done_busy", {63'b0, busy}, 64'd0);
    chk("sum", {32'b0, sum}, {32'b0, exp_sum});
    chk("cout", {63'b0, cout}, {63'b0, exp_cout});
    chk("ovf", {63'b0, ovf}, {63'b0, exp_ovf});
    chk("done_add_x", {56'b0, add_x}, 64'd0);
    last_done_cyc = cyc;
    if (!b2b) begin
      tick();
      chk("post_done", {63'b0, done}, 64'd0);
      chk("post_busy", {63'b0, busy}, 64'd0);
      chk("sum_hold", {32'b0, sum}, {32'b0, exp_sum});
      chk("cout_hold", {63'b0, cout}, {63'b0, exp_cout});
    end
  endtask

  initial begin
    int d1;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 32'h0; b = 32'h0;
    tick();
    tick();
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("idle");
    end

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0);

    // Abort mid-RUN while slice 2 is on the adder.
    a = 32'hDEADBEEF; b = 32'h01020304; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all_zero("after_abort");
    end
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held through the done cycle.
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b1);
    d1 = last_done_cyc;
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_gap", 64'(last_done_cyc - d1), 64'd5);

    for (int i = 0; i < 30; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (i % 5 == 2), (i % 3 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-word add/subtract controller that sits directly upstream of the 8-bit hybrid adder (`hybridadder8_struct`) and also consumes its result. It latches two WORDS×8-bit operands, drives one 8-bit slice per cycle into the combinational adder, and chains the adder's carry-out back in as the next carry-in. It assembles the full-width sum, carry and signed-overflow flag, and returns them with a done pulse.

## Interface

Parameters:

- WORDS, 4, number of 8-bit slices per operation (≥2); operand width W = 8·WORDS

Ports:

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when not busy
- sub  in  1  0 = A+B+cin, 1 = A−B (B inverted, cin forced to 1)
- cin  in  1  carry-in for add mode; ignored when sub=1
- a  in  W  operand A, latched on accepted start
- b  in  W  operand B, latched on accepted start
- add_x  out  8  to adder Xi: current slice of A
- add_y  out  8  to adder Yi: current slice of B (or ~B)
- add_c0  out  1  to adder C0: chained carry
- add_s  in  8  from adder Si
- add_c8  in  1  from adder C8
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; result valid
- sum  out  W  result; held until next accepted start
- cout  out  1  final carry-out (in sub mode, 1 = no borrow)
- ovf  out  1  signed overflow of the full-width result

## Operation

- States: IDLE, RUN, DONE. Reset value is IDLE.
- On reset, every output is 0. This covers busy, done, sum, cout, ovf, add_x, add_y and add_c0. Slice index and carry register are also 0.
- IDLE or DONE with start=1:
  - Latch a into a_reg; latch b into b_reg, or ~b if sub=1.
  - Set carry_reg = sub ? 1 : cin.
  - Set idx = 0. Clear sum, cout and ovf to 0.
  - Go to RUN.
- IDLE or DONE with start=0: stay. DONE returns to IDLE after one cycle.
- RUN outputs, combinational from registers:
  - add_x = a_reg[8·idx+7 : 8·idx]
  - add_y = b_reg slice idx
  - add_c0 = carry_reg
- RUN, each rising edge:
  - sum slice idx ← add_s.
  - carry_reg ← add_c8.
  - If idx = WORDS−1: go to DONE, set cout ← add_c8, and set ovf. Otherwise idx ← idx+1.
- ovf = (a_reg[W−1] == b_reg[W−1]) && (add_s[7] != a_reg[W−1]). b_reg already holds inverted B in sub mode.
- add_x, add_y and add_c0 are 0 outside RUN.
- start while busy (RUN) is ignored; the operation in progress is unaffected.
- a, b, sub and cin may change freely after acceptance; only latched copies are used.
- Arithmetic is modulo 2^W. No saturation.

## Timing

- Start is accepted at edge E0. busy is high from E0 through E(WORDS).
- Slice k is captured at edge E(k+1).
- done is high for exactly one cycle, from E(WORDS) to E(WORDS+1). Latency from accepted start to done is WORDS cycles.
- sum, cout and ovf become valid at E(WORDS) together with done. They hold until the next accepted start clears them.
- Back-to-back: start=1 during the done cycle is accepted at E(WORDS+1). RUN re-enters with no idle gap, so throughput is one op per WORDS+1 cycles.
- rst_n=0 at any edge, including mid-RUN or in DONE:
  - The next state is IDLE with all outputs 0.
  - The partial result is discarded and done is not asserted.
  - Reset has priority over start.
- The adder path is purely combinational. The slice's add_s/add_c8 must settle within one clk period of the add_x/add_y/add_c0 update.

## Test plan

All scenarios use WORDS=4 and the real hybridadder8_struct connected.

- Reset, then idle 3 cycles -> all outputs 0, busy=0, done never asserted.
- start, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> done 4 cycles after acceptance; sum=0x00000000, cout=1, ovf=0; add_c0 slices 1–3 observed as 1.
- start, a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Accept a=0x12345678, b=0x11111111, cin=1. Pulse start with new operands at cycles 1 and 2 of RUN -> ignored; sum=0x2345678A, cout=0 at done.
- Assert rst_n=0 during RUN slice 2, release, then start a=0x000000FF, b=0x00000001 -> no done from the aborted op; new result sum=0x00000100 after 4 cycles.
- Back-to-back: start held high through the done cycle with a=1, b=2 -> second op begins at the next edge; second done exactly 5 cycles after the first; sum=0x00000003.
